// File: rtl/ls_pkg.sv
// ls_pkg: shared types and constants for the RV32 load/store lane controller.
//   - f3_e        : func3 encodings of the load/store instructions
//   - LC_*        : load-extract codes driven on load_ctrl
//   - MASK_*      : byte-write mask patterns (bit i = byte lane i)
package ls_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,  // LB / SB
    F3_H  = 3'b001,  // LH / SH
    F3_W  = 3'b010,  // LW / SW
    F3_BU = 3'b100,  // LBU
    F3_HU = 3'b101   // LHU
  } f3_e;

  localparam logic [2:0] LC_LB  = 3'b000;
  localparam logic [2:0] LC_LH  = 3'b001;
  localparam logic [2:0] LC_LW  = 3'b010;
  localparam logic [2:0] LC_LBU = 3'b011;
  localparam logic [2:0] LC_LHU = 3'b100;
  localparam logic [2:0] LC_INV = 3'b111;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_LO_H = 4'b0011;
  localparam logic [3:0] MASK_HI_H = 4'b1100;
  localparam logic [3:0] MASK_ALL  = 4'b1111;

endpackage

// File: rtl/ls_controller_if.sv
// ls_controller_if: Memory-stage load/store bus between the pipeline and
// ls_controller.
//   master (pipeline): drives func3, address, rdata2, mem_wr, mem_read;
//                      receives wdata_mem, load_ctrl, mask, misaligned,
//                      misalign_err.
//   slave  (ls_controller): the mirror image.
interface ls_controller_if;

  logic [2:0]  func3;
  logic [1:0]  address;
  logic [31:0] rdata2;
  logic        mem_wr;
  logic        mem_read;
  logic [31:0] wdata_mem;
  logic [2:0]  load_ctrl;
  logic [3:0]  mask;
  logic        misaligned;
  logic        misalign_err;

  modport master (
    output func3, address, rdata2, mem_wr, mem_read,
    input  wdata_mem, load_ctrl, mask, misaligned, misalign_err
  );

  modport slave (
    input  func3, address, rdata2, mem_wr, mem_read,
    output wdata_mem, load_ctrl, mask, misaligned, misalign_err
  );

endinterface

// File: rtl/ls_store_lane.sv
// ls_store_lane: store lane steering, purely combinational.
//   func3     in  3   store width (SB/SH/SW; others write nothing)
//   address   in  2   byte offset within the word
//   rdata2    in  32  rs2 store data
//   mask      out 4   byte-write enable before any misalignment suppression
//   wdata_mem out 32  store data replicated so every enabled lane sees its byte
module ls_store_lane
  import ls_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  address,
  input  logic [31:0] rdata2,
  output logic [3:0]  mask,
  output logic [31:0] wdata_mem
);

  // NOTE: every output gets a default before the case so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mask      = MASK_NONE;
    wdata_mem = rdata2;
    case (func3)
      F3_B: begin
        mask      = 4'b0001 << address;
        wdata_mem = {4{rdata2[7:0]}};
      end
      F3_H: begin
        // Only address[1] selects the half; address[0] is a misalignment
        // concern handled by the top.
        mask      = address[1] ? MASK_HI_H : MASK_LO_H;
        wdata_mem = {2{rdata2[15:0]}};
      end
      F3_W: begin
        mask = MASK_ALL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ls_controller.sv
// ls_controller: load/store lane controller for the RV32 data memory
// (Memory stage). Decode is combinational; one sticky misalignment flag is
// registered.
//   clk  in  1  clock
//   rst  in  1  synchronous, active-high reset
//   bus  slave modport of ls_controller_if:
//     func3, address, rdata2, mem_wr, mem_read -> in
//     wdata_mem, load_ctrl, mask, misaligned, misalign_err -> out
// Build option: define MISALIGN_TRAP_EN to detect misaligned halfword/word
// accesses, suppress misaligned stores and keep a sticky error flag.
// Without it, misaligned/misalign_err are tied 0 and misaligned stores write.
module ls_controller
  import ls_pkg::*;
(
  input logic          clk,
  input logic          rst,
  ls_controller_if.slave bus
);

  logic [3:0] lane_mask;

  ls_store_lane u_store_lane (
    .func3     (bus.func3),
    .address   (bus.address),
    .rdata2    (bus.rdata2),
    .mask      (lane_mask),
    .wdata_mem (bus.wdata_mem)
  );

  always_comb begin
    bus.load_ctrl = LC_INV;
    case (bus.func3)
      F3_B:    bus.load_ctrl = LC_LB;
      F3_H:    bus.load_ctrl = LC_LH;
      F3_W:    bus.load_ctrl = LC_LW;
      F3_BU:   bus.load_ctrl = LC_LBU;
      F3_HU:   bus.load_ctrl = LC_LHU;
      default: bus.load_ctrl = LC_INV;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_err_q;

  // Width comes from func3[1:0] so loads (LHU) and stores share the check.
  always_comb begin
    misaligned = 1'b0;
    case (bus.func3[1:0])
      2'b01:   misaligned = bus.address[0];
      2'b10:   misaligned = (bus.address != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // NOTE: state uses non-blocking assignment so every flop samples
  // pre-edge values; rst is checked first so it beats a coincident set.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err_q <= 1'b0;
    end else if ((bus.mem_wr | bus.mem_read) & misaligned) begin
      misalign_err_q <= 1'b1;
    end
  end

  assign bus.mask         = misaligned ? MASK_NONE : lane_mask;
  assign bus.misaligned   = misaligned;
  assign bus.misalign_err = misalign_err_q;
`else
  // Access-valid strobes and the clock only feed the sticky flag, which is
  // not built in this configuration.
  logic unused_no_trap;
  assign unused_no_trap   = ^{clk, rst, bus.mem_wr, bus.mem_read};

  assign bus.mask         = lane_mask;
  assign bus.misaligned   = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ls_controller.sv
// tb_ls_controller: directed self-checking bench for ls_controller.
// Expectations follow the active build (MISALIGN_TRAP_EN defined or not).
module tb_ls_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ls_controller_if bus_if ();

  ls_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well clear of the rising edge.
  task automatic apply(input logic [2:0] f3, input logic [1:0] addr,
                       input logic [31:0] data, input logic wr, input logic rd);
    @(negedge clk);
    bus_if.func3    = f3;
    bus_if.address  = addr;
    bus_if.rdata2   = data;
    bus_if.mem_wr   = wr;
    bus_if.mem_read = rd;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] f3_vec [6];
    logic [2:0] lc_vec [6];
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    bus_if.func3    = 3'b000;
    bus_if.address  = 2'b00;
    bus_if.rdata2   = 32'h0;
    bus_if.mem_wr   = 1'b0;
    bus_if.mem_read = 1'b0;
    after_edge();
    after_edge();
    check("reset_err", {31'b0, bus_if.misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Byte stores
    apply(3'b000, 2'd2, 32'h1234_56AB, 1'b1, 1'b0);
    check("sb_a2_mask", {28'b0, bus_if.mask}, 32'b0100);
    check("sb_a2_data", bus_if.wdata_mem, 32'hABAB_ABAB);
    check("sb_a2_mis",  {31'b0, bus_if.misaligned}, 32'd0);
    apply(3'b000, 2'd3, 32'h0000_0077, 1'b1, 1'b0);
    check("sb_a3_mask", {28'b0, bus_if.mask}, 32'b1000);
    check("sb_a3_data", bus_if.wdata_mem, 32'h7777_7777);
    apply(3'b000, 2'd1, 32'h0000_0055, 1'b0, 1'b0);
    check("sb_a1_mask_nowr", {28'b0, bus_if.mask}, 32'b0010);

    // Halfword stores
    apply(3'b001, 2'd2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("sh_a2_mask", {28'b0, bus_if.mask}, 32'b1100);
    check("sh_a2_data", bus_if.wdata_mem, 32'hBEEF_BEEF);
    apply(3'b001, 2'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("sh_a0_mask", {28'b0, bus_if.mask}, 32'b0011);

    // Word stores and invalid store func3
    apply(3'b010, 2'd0, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("sw_a0_mask", {28'b0, bus_if.mask}, 32'b1111);
    check("sw_a0_data", bus_if.wdata_mem, 32'hCAFE_F00D);
    apply(3'b111, 2'd0, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("f3_111_mask", {28'b0, bus_if.mask}, 32'b0000);
    check("f3_111_data", bus_if.wdata_mem, 32'hCAFE_F00D);
    apply(3'b011, 2'd0, 32'h1111_2222, 1'b0, 1'b0);
    check("f3_011_mask", {28'b0, bus_if.mask}, 32'b0000);

    // load_ctrl sweep
    f3_vec = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    lc_vec = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    for (int i = 0; i < 6; i++) begin
      apply(f3_vec[i], 2'd0, 32'h0, 1'b0, 1'b1);
      check($sformatf("load_ctrl_f3_%03b", f3_vec[i]),
            {29'b0, bus_if.load_ctrl}, {29'b0, lc_vec[i]});
    end
    apply(3'b110, 2'd0, 32'h0, 1'b0, 1'b0);
    check("load_ctrl_f3_110", {29'b0, bus_if.load_ctrl}, 32'd7);
    after_edge();
    check("aligned_err", {31'b0, bus_if.misalign_err}, 32'd0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word store: suppressed, flagged, sticky
    apply(3'b010, 2'd1, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("sw_a1_mis",  {31'b0, bus_if.misaligned}, 32'd1);
    check("sw_a1_mask", {28'b0, bus_if.mask}, 32'b0000);
    check("sw_a1_err_pre", {31'b0, bus_if.misalign_err}, 32'd0);
    after_edge();
    check("sw_a1_err_set", {31'b0, bus_if.misalign_err}, 32'd1);
    apply(3'b000, 2'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check($sformatf("err_hold_%0d", i), {31'b0, bus_if.misalign_err}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    after_edge();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("err_after_rst", {31'b0, bus_if.misalign_err}, 32'd0);

    // Misaligned halfword store suppressed too
    apply(3'b001, 2'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("sh_a3_mis",  {31'b0, bus_if.misaligned}, 32'd1);
    check("sh_a3_mask", {28'b0, bus_if.mask}, 32'b0000);

    // Misaligned LH with no access valid: flag only combinational
    apply(3'b001, 2'd1, 32'h0, 1'b0, 1'b0);
    check("lh_a1_mis", {31'b0, bus_if.misaligned}, 32'd1);
    after_edge();
    check("lh_a1_noacc_err", {31'b0, bus_if.misalign_err}, 32'd0);

    // Misaligned LHU load with mem_read sets the flag
    apply(3'b101, 2'd1, 32'h0, 1'b0, 1'b1);
    check("lhu_a1_mis", {31'b0, bus_if.misaligned}, 32'd1);
    after_edge();
    check("lhu_a1_err", {31'b0, bus_if.misalign_err}, 32'd1);

    // rst coinciding with a set: rst wins
    @(negedge clk);
    rst = 1'b1;
    bus_if.func3  = 3'b010;
    bus_if.address = 2'd2;
    bus_if.mem_wr = 1'b1;
    after_edge();
    check("rst_beats_set", {31'b0, bus_if.misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.mem_wr = 1'b0;
`else
    // Without the trap, misaligned stores write and nothing is flagged
    apply(3'b010, 2'd1, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("sw_a1_mis",  {31'b0, bus_if.misaligned}, 32'd0);
    check("sw_a1_mask", {28'b0, bus_if.mask}, 32'b1111);
    check("sw_a1_data", bus_if.wdata_mem, 32'hCAFE_F00D);
    after_edge();
    check("sw_a1_err", {31'b0, bus_if.misalign_err}, 32'd0);
    apply(3'b001, 2'd1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("sh_a1_mask", {28'b0, bus_if.mask}, 32'b0011);
    apply(3'b001, 2'd3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("sh_a3_mask", {28'b0, bus_if.mask}, 32'b1100);
    check("sh_a3_mis",  {31'b0, bus_if.misaligned}, 32'd0);
    apply(3'b101, 2'd1, 32'h0, 1'b0, 1'b1);
    after_edge();
    check("lhu_a1_err", {31'b0, bus_if.misalign_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
